imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. The fetch stage is the reader.
- Accepts a byte stream carrying a program image: a 2-byte length header, then payload words.
- Assembles the payload into 32-bit little-endian words and writes them sequentially into the instruction memory write port.
- Holds the processor core in reset until the image is fully loaded, then releases it so the pipeline starts fetching from PC 0.

Parameters:
- BASE_ADDR, default 32'h0000_0000: byte address of the first word written; must be word aligned.
- MAX_WORDS, default 1024: largest accepted image, in words.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- InByte  input  8  stream data byte.
- InValid  input  1  InByte holds a valid byte.
- InReady  output  1  loader can accept a byte; transfer occurs when InValid && InReady at the rising Clk edge.
- ImemWrEn  output  1  one-cycle instruction memory write strobe.
- ImemWrAddr  output  32  byte address of the write, word aligned.
- ImemWrData  output  32  word to write.
- CoreRst  output  1  reset to the processor (drives PC_Rst); active high.
- Done  output  1  image loaded successfully; sticky.
- Error  output  1  image rejected; sticky.
- WordCount  output  16  number of words written so far.

Behaviour:
- Reset is asynchronous and active-high. On Rst: state=HDR0, ImemWrEn=0, ImemWrAddr=BASE_ADDR, ImemWrData=0, CoreRst=1, Done=0, Error=0, WordCount=0, byte index=0, InReady=1.
- States: HDR0, HDR1, LOAD, CHK (only with the macro), DONE, ERROR.
- InReady is combinational from state: 1 in HDR0/HDR1/LOAD/CHK, 0 in DONE/ERROR.
- Cycles with InValid=0 do not advance any state.
- HDR0: accept a byte into N[7:0] -> HDR1.
- HDR1: accept a byte into N[15:8], then branch:
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERROR.
  - otherwise -> LOAD.
- LOAD: byte k of the current word goes into bits [8k+7:8k] (little-endian); k counts 0..3.
  - On acceptance of byte 3 at edge E: ImemWrEn=1 for exactly one cycle after E.
  - At that same edge E, ImemWrData=assembled word, ImemWrAddr=BASE_ADDR+4*WordCount (pre-increment), and WordCount increments.
  - If this was word N-1: state -> DONE (or CHK with the macro) at E. Otherwise stay in LOAD with k=0.
  - A new byte may be accepted in the same cycle ImemWrEn is high. There is no backpressure; the memory write port is single-cycle.
- DONE: Done=1 from the entering edge. CoreRst deasserts at the following edge, so the core stays in reset through the final write cycle. InReady=0 and further bytes are ignored.
- ERROR: Error=1, CoreRst stays 1, InReady=0. Only Rst exits.
- Rst mid-load: immediately returns to reset state with CoreRst=1. Instruction memory contents are not cleared; a fresh header restarts the load at BASE_ADDR.
- ImemWrAddr holds its last value when ImemWrEn=0. Address arithmetic is 32-bit modulo.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes (header excluded) is kept; it is cleared on reset.
  - After the last word, the state goes to CHK and accepts one byte.
  - Byte equals the XOR -> DONE; otherwise -> ERROR.
  - With N==0, HDR1 goes to CHK, and the expected checksum is 0x00.
- Undefined: no CHK state; the last word goes directly to DONE; no checksum byte is consumed.

Test Plan:
- Continuous stream:
  - Stimulus after reset release: 02 00 05 00 08 20 0A 00 09 20.
  - Writes: 0x20080005 @0x0, then 0x2009000A @0x4, each ImemWrEn one cycle.
  - WordCount=2, Done=1. CoreRst falls one edge after the second write. Error=0.
- Empty image:
  - Stimulus: 00 00.
  - No ImemWrEn. Done=1 after the second byte (macro off).
  - With the macro on, byte 00 is needed -> Done=1.
- Oversized header:
  - Stimulus: 01 04 (N=1025).
  - Error=1, InReady=0, CoreRst stays 1, no writes. Later bytes are ignored.
- Gapped stream:
  - Stimulus: test 1's bytes with random InValid=0 gaps of 0-5 cycles.
  - Identical write sequence and data. No writes during gaps.
- Reset mid-load:
  - Stimulus: header 01 00, 2 payload bytes, Rst pulse, then 01 00 78 56 34 12.
  - Outputs return to reset values asynchronously.
  - Single write 0x12345678 @BASE_ADDR, WordCount=1, Done=1.
- Checksum (macro on):
  - Stimulus: 01 00 11 22 44 88 FF -> Done=1.
  - Same with a final byte of FE -> Error=1, CoreRst=1; the write of 0x88442211 still occurs.

Source files
------------

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// Module      : imem_loader
// Description : Byte-stream program loader; writes a length-prefixed image into
//               instruction memory and holds the core in reset until it is loaded.
//               Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  InByte,
    input  logic        InValid,
    output logic        InReady,
    output logic        ImemWrEn,
    output logic [31:0] ImemWrAddr,
    output logic [31:0] ImemWrData,
    output logic        CoreRst,
    output logic        Done,
    output logic        Error,
    output logic [15:0] WordCount
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_LOAD  = 3'd2,
        S_CHK   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

    state_t      state;
    logic [15:0] len;
    logic [1:0]  idx;
    logic [23:0] partial;
    logic        accept;
    logic [15:0] hdr_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign InReady = (state == S_HDR0) || (state == S_HDR1) ||
                     (state == S_LOAD) || (state == S_CHK);
    assign accept  = InValid && InReady;
    assign hdr_len = {InByte, len[7:0]};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= S_HDR0;
            len        <= 16'd0;
            idx        <= 2'd0;
            partial    <= 24'd0;
            ImemWrEn   <= 1'b0;
            ImemWrAddr <= BASE_ADDR;
            ImemWrData <= 32'd0;
            CoreRst    <= 1'b1;
            Done       <= 1'b0;
            Error      <= 1'b0;
            WordCount  <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            ImemWrEn <= 1'b0;
            case (state)
                S_HDR0: begin
                    if (accept) begin
                        len[7:0] <= InByte;
                        state    <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        len[15:8] <= InByte;
                        if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state <= S_DONE;
                            Done  <= 1'b1;
`endif
                        end else if ({1'b0, hdr_len} > c_max_words) begin
                            state <= S_ERROR;
                            Error <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ InByte;
`endif
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: partial[7:0]   <= InByte;
                            2'd1: partial[15:8]  <= InByte;
                            2'd2: partial[23:16] <= InByte;
                            default: begin
                                // Address uses the pre-increment count.
                                ImemWrEn   <= 1'b1;
                                ImemWrData <= {InByte, partial};
                                ImemWrAddr <= BASE_ADDR + {14'd0, WordCount, 2'b00};
                                WordCount  <= WordCount + 16'd1;
                                if (WordCount + 16'd1 == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state <= S_CHK;
`else
                                    state <= S_DONE;
                                    Done  <= 1'b1;
`endif
                                end
                            end
                        endcase
                    end
                end
                S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        if (InByte == csum) begin
                            state <= S_DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            Error <= 1'b1;
                        end
                    end
`endif
                end
                // Core leaves reset one edge after Done rises, after the final write.
                S_DONE:  CoreRst <= 1'b0;
                S_ERROR: CoreRst <= 1'b1;
                default: begin
                    state <= S_ERROR;
                    Error <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (IMEM_LOADER_CHECKSUM_EN aware).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        Clk;
    logic        Rst;
    logic [7:0]  InByte;
    logic        InValid;
    logic        InReady;
    logic        ImemWrEn;
    logic [31:0] ImemWrAddr;
    logic [31:0] ImemWrData;
    logic        CoreRst;
    logic        Done;
    logic        Error;
    logic [15:0] WordCount;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .InByte     (InByte),
        .InValid    (InValid),
        .InReady    (InReady),
        .ImemWrEn   (ImemWrEn),
        .ImemWrAddr (ImemWrAddr),
        .ImemWrData (ImemWrData),
        .CoreRst    (CoreRst),
        .Done       (Done),
        .Error      (Error),
        .WordCount  (WordCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [95:0] bytes;   // first stream byte is the most significant used byte
        int          nb;
        logic        done;
        logic        err;
        logic [15:0] wc;
    } vec_t;

    vec_t        v[5];
    logic [63:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge Clk) begin
        if (Rst === 1'b0 && ImemWrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got %08h@%08h expected none", ImemWrData, ImemWrAddr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", ImemWrAddr, e[63:32]);
                chk("wr_data", ImemWrData, e[31:0]);
            end
        end
    end

    function automatic logic [7:0] vb(input vec_t x, input int i);
        return x.bytes[8*(x.nb-1-i) +: 8];
    endfunction

    task automatic send(input logic [7:0] b);
        InByte  = b;
        InValid = 1'b1;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        #3;
        chk("rst_corerst", 32'(CoreRst), 32'd1);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        chk("rst_wordcount", 32'(WordCount), 32'd0);
        chk("rst_wren", 32'(ImemWrEn), 32'd0);
        chk("rst_addr", ImemWrAddr, BASE);
        chk("rst_data", ImemWrData, 32'd0);
        chk("rst_inready", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    // Reference model: expected writes derived from the header and payload bytes.
    task automatic model_push(input vec_t x);
        int n;
        n = int'({vb(x, 1), vb(x, 0)});
        if (n != 0 && n <= 1024) begin
            for (int w = 0; w < n && 2 + 4*w + 3 < x.nb; w++)
                exp_q.push_back({BASE + 32'(4*w),
                                 vb(x, 5+4*w), vb(x, 4+4*w), vb(x, 3+4*w), vb(x, 2+4*w)});
        end
    endtask

    task automatic end_checks(input string name, input logic done, input logic err,
                              input logic [15:0] wc);
        idle(3);
        chk({name, "_done"}, 32'(Done), 32'(done));
        chk({name, "_error"}, 32'(Error), 32'(err));
        chk({name, "_wordcount"}, 32'(WordCount), 32'(wc));
        chk({name, "_corerst"}, 32'(CoreRst), 32'(!done));
        chk({name, "_inready"}, 32'(InReady), 32'(!(done || err)));
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Rst     = 1'b1;
        InValid = 1'b0;
        InByte  = 8'h00;

        v[0] = '{96'h02_00_05_00_08_20_0A_00_09_20, 10, 1'b1, 1'b0, 16'd2};
        v[1] = '{96'h00_00,                          2, 1'b1, 1'b0, 16'd0};
        v[2] = '{96'h01_04_AA_BB_CC_DD,              6, 1'b0, 1'b1, 16'd0};
        v[3] = '{96'h00_04_01_02_03_04,              6, 1'b0, 1'b0, 16'd1};
        v[4] = '{96'h01_00_EF_BE_AD_DE,              6, 1'b1, 1'b0, 16'd1};
`ifdef IMEM_LOADER_CHECKSUM_EN
        v[0].bytes = (v[0].bytes << 8) | 96'h0E; v[0].nb++;
        v[1].bytes = (v[1].bytes << 8) | 96'h00; v[1].nb++;
        v[4].bytes = (v[4].bytes << 8) | 96'h22; v[4].nb++;
`endif

        for (int i = 0; i < 5; i++) begin
            do_reset();
            model_push(v[i]);
            for (int j = 0; j < v[i].nb; j++) send(vb(v[i], j));
            end_checks($sformatf("vec%0d", i), v[i].done, v[i].err, v[i].wc);
        end

        // Gapped stream: same image with random idle cycles between bytes.
        do_reset();
        model_push(v[0]);
        for (int j = 0; j < v[0].nb; j++) begin
            idle(int'($urandom_range(0, 5)));
            send(vb(v[0], j));
        end
        end_checks("gapped", 1'b1, 1'b0, 16'd2);

        // Reset in the middle of a word, then a fresh image from BASE.
        do_reset();
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        do_reset();
        exp_q.push_back({BASE, 32'h1234_5678});
        send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h08);
`endif
        end_checks("midreset", 1'b1, 1'b0, 16'd1);

`ifndef IMEM_LOADER_CHECKSUM_EN
        // Core stays in reset through the final write cycle, released one edge later.
        do_reset();
        model_push(v[0]);
        for (int j = 0; j < 9; j++) send(vb(v[0], j));
        send(8'h20);
        chk("final_wren", 32'(ImemWrEn), 32'd1);
        chk("final_done", 32'(Done), 32'd1);
        chk("final_corerst_held", 32'(CoreRst), 32'd1);
        idle(1);
        chk("release_corerst", 32'(CoreRst), 32'd0);
        chk("release_wren", 32'(ImemWrEn), 32'd0);
        end_checks("release", 1'b1, 1'b0, 16'd2);
`else
        do_reset();
        exp_q.push_back({BASE, 32'h8844_2211});
        send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h44); send(8'h88);
        send(8'hFF);
        end_checks("csum_good", 1'b1, 1'b0, 16'd1);

        do_reset();
        exp_q.push_back({BASE, 32'h8844_2211});
        send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h44); send(8'h88);
        send(8'hFE);
        end_checks("csum_bad", 1'b0, 1'b1, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
